branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Owns the fetch PC and carries each fetched instruction's prediction (hit, predicted next PC) through the IF/ID and ID/EX stages.
- In EX it resolves the real branch/jump outcome and compares it with the prediction.
- On a wrong prediction it issues a flush and redirects the PC.
- It drives pc_ex/hit_ex/wrong_predicted back to the 2-bit branch predictor for training. It is the consumer end of the predictor interface.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- stall_i  in  1  load-use stall: freeze PC and IF/ID, bubble into EX
- bp_hit_i  in  1  predictor says taken for current pc_o
- bp_target_i  in  32  predicted target for current pc_o
- inst_ex_i  in  32  instruction in EX
- br_eq_i  in  1  rs1==rs2 from comparator
- br_lt_i  in  1  rs1<rs2, signedness per funct3, from comparator
- alu_i  in  32  computed target (pc+imm or rs1+imm) in EX
- pc_o  out  32  fetch PC
- pc_ex_o  out  32  PC of the EX slot
- hit_ex_o  out  1  prediction carried with the EX slot
- wrong_predicted_o  out  2  00 ok, 01 predicted taken/not taken, 10 predicted not taken/taken, 11 taken/target mismatch
- flush_o  out  1  squash IF/ID and ID/EX contents this cycle
- branch_cnt_o  out  CNT_W  resolved control-flow instructions
- mispredict_cnt_o  out  CNT_W  flushes issued

Behaviour:
Clock and reset:
- One clock, clk_i. rst_i is synchronous and active-high.
- Reset values: pc_o=RESET_PC; all stage valid bits=0; pc_ex_o=0; hit_ex_o=0; wrong_predicted_o=00; flush_o=0; counters=0; FSM=RUN.
- rst_i asserted mid-flush or mid-stall overrides everything at the next edge.

Metadata pipeline (per stage: valid, pc, hit, pred_next):
- IF capture: pc=pc_o, hit=bp_hit_i, pred_next = bp_hit_i ? bp_target_i : pc_o+4.
- IF/ID and ID/EX update every cycle unless a stall or flush applies.
- stall_i: pc_o and IF/ID hold; ID/EX loads valid=0.

EX resolution (combinational, only when ex.valid=1):
- taken = JAL | JALR | (B-type & condition). Conditions: BEQ eq; BNE ~eq; BLT/BLTU lt; BGE/BGEU ~lt.
- Any other opcode: taken=0.
- actual_next = taken ? alu_i : ex.pc+4. All +4 arithmetic wraps modulo 2^32.
- wrong_predicted_o:
  - 01 if hit & ~taken
  - 10 if ~hit & taken
  - 11 if hit & taken & alu_i!=ex.pred_next
  - else 00
- flush_o = ex.valid & (actual_next != ex.pred_next). A direction mismatch with equal addresses, e.g. a branch to pc+4, reports its code but does not flush.
- ex.valid=0 forces wrong_predicted_o=00 and flush_o=0. hit_ex_o and pc_ex_o are still driven from the register.

Next PC priority:
1. rst_i → RESET_PC
2. flush_o → actual_next
3. stall_i → hold
4. bp_hit_i → bp_target_i
5. else pc_o+4

- Flush beats stall. On flush, IF/ID and ID/EX load valid=0 regardless of stall_i.
- Misprediction penalty: 2 cycles.

FSM:
- RUN: flush_o → RECOVER.
- RECOVER: lasts exactly 1 cycle, → RUN.
  - In RECOVER the EX slot is a squashed bubble: ex.valid=0, so no second flush.
  - A flush observed in RECOVER is illegal. An assertion must fire.

Counters:
- branch_cnt_o increments when ex.valid & (B-type|JAL|JALR).
- mispredict_cnt_o increments on flush_o.
- Both wrap at 2^CNT_W. Neither increments while rst_i is high.

Decomposition:
- Shared package rv32_pkg: opcode constants (OP_BTYPE, OP_JAL, OP_JALR), funct3 constants (BEQ..BGEU), wrong_predicted codes as a 2-bit enum, FSM state enum, stage-metadata packed struct (valid, pc, hit, pred_next).
- One sub-module is natural: branch_outcome (combinational: inst, eq, lt → taken, is_ctrl). It can be reused by other pipeline variants.

Test Plan:
1. Reset: rst_i=1 for 2 cycles with RESET_PC=32'h100 → pc_o=32'h100, flush_o=0, counters=0. Sequential fetch then gives 104, 108.
2. BEQ at 0x110, predicted not taken, eq=1, alu_i=0x200 → in the EX cycle wrong_predicted_o=10 and flush_o=1. Next cycle pc_o=0x200 and the two younger slots are invalid. mispredict_cnt_o=1.
3. BNE at 0x120, bp_hit_i=1 with target 0x80, eq=1 (not taken) → wrong_predicted_o=01, flush, pc_o=0x124.
4. JALR at 0x140, hit with target 0x300, alu_i=0x304 → wrong_predicted_o=11, pc_o=0x304. A correct target 0x300 gives code 00, no flush, branch_cnt_o increments.
5. stall_i=1 in the same cycle as a flush at 0x150 (taken to 0x400) → pc_o=0x400, both slots squashed. Stall alone for 3 cycles: pc_o held and EX sees 3 bubbles.
6. Wrap: pc_o=0xFFFF_FFFC with no hit → next pc_o=0x0. BEQ at 0x160 to 0x164, taken, predicted not taken → code 10, flush_o=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 control-flow definitions: opcodes, branch funct3 codes,
// misprediction codes, resolve FSM states and per-stage prediction metadata.
package rv32_pkg;

    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        WP_OK       = 2'b00,
        WP_TAKEN_NT = 2'b01,
        WP_NT_TAKEN = 2'b10,
        WP_TARGET   = 2'b11
    } wp_code_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        hit;
        logic [31:0] pred_next;
    } stage_meta_t;

endpackage

// File: rtl/branch_outcome.sv
// Combinational decode of a control-flow instruction's real direction from
// the opcode, funct3 and the comparator flags.
module branch_outcome
    import rv32_pkg::*;
(
    input  logic [31:0] inst,
    input  logic        eq,
    input  logic        lt,
    output logic        taken,
    output logic        is_ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign unused_bits = ^{inst[31:15], inst[11:7]};

    always_comb begin
        taken   = 1'b0;
        is_ctrl = 1'b0;
        case (opcode)
            OP_JAL, OP_JALR: begin
                taken   = 1'b1;
                is_ctrl = 1'b1;
            end
            OP_BTYPE: begin
                is_ctrl = 1'b1;
                case (funct3)
                    F3_BEQ:           taken = eq;
                    F3_BNE:           taken = ~eq;
                    F3_BLT, F3_BLTU:  taken = lt;
                    F3_BGE, F3_BGEU:  taken = ~lt;
                    default:          taken = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Fetch PC owner: carries prediction metadata to EX, resolves the real
// outcome there, and flushes/redirects on a misprediction.
module branch_resolve_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             bp_hit_i,
    input  logic [31:0]      bp_target_i,
    input  logic [31:0]      inst_ex_i,
    input  logic             br_eq_i,
    input  logic             br_lt_i,
    input  logic [31:0]      alu_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_ex_o,
    output logic             hit_ex_o,
    output logic [1:0]       wrong_predicted_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_meta_t if_meta;
    stage_meta_t slot_p1;
    stage_meta_t slot_p2;
    logic        taken;
    logic        is_ctrl;
    logic [31:0] actual_next;
    wp_code_e    wp;
    state_e      state_q;
    state_e      state_d;

    branch_outcome u_outcome (
        .inst    (inst_ex_i),
        .eq      (br_eq_i),
        .lt      (br_lt_i),
        .taken   (taken),
        .is_ctrl (is_ctrl)
    );

    always_comb begin
        if_meta.valid     = 1'b1;
        if_meta.pc        = pc_o;
        if_meta.hit       = bp_hit_i;
        if_meta.pred_next = bp_hit_i ? bp_target_i : pc_o + 32'd4;
    end

    // EX: compare the resolved next PC against what fetch assumed
    always_comb begin
        actual_next = taken ? alu_i : slot_p2.pc + 32'd4;
        wp          = WP_OK;
        flush_o     = 1'b0;
        if (slot_p2.valid) begin
            if (slot_p2.hit && !taken)
                wp = WP_TAKEN_NT;
            else if (!slot_p2.hit && taken)
                wp = WP_NT_TAKEN;
            else if (slot_p2.hit && taken && (alu_i != slot_p2.pred_next))
                wp = WP_TARGET;
            flush_o = (actual_next != slot_p2.pred_next);
        end
    end

    assign wrong_predicted_o = wp;
    assign pc_ex_o           = slot_p2.pc;
    assign hit_ex_o          = slot_p2.hit;

    // IF -> IF/ID -> ID/EX; a flush squashes both slots even under stall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_o    <= RESET_PC;
            slot_p1 <= '0;
            slot_p2 <= '0;
        end else if (flush_o) begin
            pc_o    <= actual_next;
            slot_p1 <= '{valid: 1'b0, pc: if_meta.pc, hit: if_meta.hit, pred_next: if_meta.pred_next};
            slot_p2 <= '{valid: 1'b0, pc: slot_p1.pc, hit: slot_p1.hit, pred_next: slot_p1.pred_next};
        end else if (stall_i) begin
            slot_p2 <= '{valid: 1'b0, pc: slot_p1.pc, hit: slot_p1.hit, pred_next: slot_p1.pred_next};
        end else begin
            pc_o    <= if_meta.pred_next;
            slot_p1 <= if_meta;
            slot_p2 <= slot_p1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (flush_o) state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_RUN;
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            if (slot_p2.valid && is_ctrl)
                branch_cnt_o <= branch_cnt_o + CNT_ONE;
            if (flush_o)
                mispredict_cnt_o <= mispredict_cnt_o + CNT_ONE;
        end
    end

    // The recovery cycle always holds a squashed bubble, so it can never flush
    recover_no_flush: assert property (@(posedge clk_i) disable iff (rst_i)
        !(state_q == ST_RECOVER && flush_o));

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized bench for branch_resolve_unit against an in-bench model of the
// fetch/decode/execute prediction flow.
module tb_branch_resolve_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          CW     = 4;
    localparam int          CMOD   = 1 << CW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          stall_i;
    logic          bp_hit_i;
    logic [31:0]   bp_target_i;
    logic [31:0]   inst_ex_i;
    logic          br_eq_i;
    logic          br_lt_i;
    logic [31:0]   alu_i;
    logic [31:0]   pc_o;
    logic [31:0]   pc_ex_o;
    logic          hit_ex_o;
    logic [1:0]    wrong_predicted_o;
    logic          flush_o;
    logic [CW-1:0] branch_cnt_o;
    logic [CW-1:0] mispredict_cnt_o;

    branch_resolve_unit #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .stall_i           (stall_i),
        .bp_hit_i          (bp_hit_i),
        .bp_target_i       (bp_target_i),
        .inst_ex_i         (inst_ex_i),
        .br_eq_i           (br_eq_i),
        .br_lt_i           (br_lt_i),
        .alu_i             (alu_i),
        .pc_o              (pc_o),
        .pc_ex_o           (pc_ex_o),
        .hit_ex_o          (hit_ex_o),
        .wrong_predicted_o (wrong_predicted_o),
        .flush_o           (flush_o),
        .branch_cnt_o      (branch_cnt_o),
        .mispredict_cnt_o  (mispredict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Model: fetch PC plus the two in-flight instruction records.
    logic [31:0] m_pc;
    logic        id_v, id_hit, id_known;
    logic [31:0] id_pc, id_pred;
    logic        ex_v, ex_hit, ex_known;
    logic [31:0] ex_pc, ex_pred;
    int          m_br, m_mp;

    logic [31:0] pool [6] = '{32'h80, 32'h200, 32'h300, 32'h304, 32'h400, 32'hFFFF_FFFC};

    function automatic logic is_ctrl_f(input logic [31:0] inst);
        return inst[6:0] == 7'h63 || inst[6:0] == 7'h6F || inst[6:0] == 7'h67;
    endfunction

    function automatic logic taken_f(input logic [31:0] inst, input logic eq, input logic lt);
        if (inst[6:0] == 7'h6F || inst[6:0] == 7'h67) return 1'b1;
        if (inst[6:0] != 7'h63) return 1'b0;
        case (inst[14:12])
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        id_v = 0; id_hit = 0; id_pc = 0; id_pred = 0; id_known = 1;
        ex_v = 0; ex_hit = 0; ex_pc = 0; ex_pred = 0; ex_known = 1;
        m_br = 0; m_mp = 0;
    endtask

    initial begin
        logic        tk, e_flush;
        logic [31:0] actual, nxt;
        logic [1:0]  e_wp;
        int          k;

        rst_i = 1; stall_i = 0; bp_hit_i = 0; bp_target_i = 0;
        inst_ex_i = 0; br_eq_i = 0; br_lt_i = 0; alu_i = 0;
        repeat (2) @(posedge clk_i);
        model_reset();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk_i);
            rst_i    = ($urandom_range(0, 99) == 0);
            stall_i  = (cyc > 3) && ($urandom_range(0, 99) < 15);
            bp_hit_i = (cyc > 3) && ($urandom_range(0, 99) < 30);
            bp_target_i = pool[$urandom_range(0, 5)];
            k = $urandom_range(0, 4);
            inst_ex_i = $urandom;
            case (k)
                0, 1: inst_ex_i[6:0] = 7'h63;
                2:    inst_ex_i[6:0] = 7'h6F;
                3:    inst_ex_i[6:0] = 7'h67;
                default: inst_ex_i[6:0] = 7'h33;
            endcase
            br_eq_i = $urandom_range(0, 1);
            br_lt_i = $urandom_range(0, 1);
            k = $urandom_range(0, 3);
            alu_i = (k == 0) ? ex_pred : (k == 1) ? ex_pc + 32'd4 : pool[$urandom_range(0, 5)];
            #1;

            tk     = taken_f(inst_ex_i, br_eq_i, br_lt_i);
            actual = tk ? alu_i : ex_pc + 32'd4;
            e_wp   = 2'b00;
            if (ex_v && (ex_hit != tk)) e_wp = ex_hit ? 2'b01 : 2'b10;
            else if (ex_v && ex_hit && tk && alu_i != ex_pred) e_wp = 2'b11;
            e_flush = ex_v && (actual != ex_pred);

            if (cyc == 0) chk("reset_pc", pc_o, 32'h100);
            chk("pc_o", pc_o, m_pc);
            chk("flush", flush_o, e_flush);
            chk("wrong_pred", wrong_predicted_o, e_wp);
            chk("branch_cnt", branch_cnt_o, m_br);
            chk("mispredict_cnt", mispredict_cnt_o, m_mp);
            if (ex_known) begin
                chk("pc_ex", pc_ex_o, ex_pc);
                chk("hit_ex", hit_ex_o, ex_hit);
            end

            if (rst_i) begin
                model_reset();
            end else begin
                if (ex_v && is_ctrl_f(inst_ex_i)) m_br = (m_br + 1) % CMOD;
                if (e_flush) begin
                    m_mp = (m_mp + 1) % CMOD;
                    m_pc = actual;
                    id_v = 0; id_known = 0;
                    ex_v = 0; ex_known = 0;
                end else if (stall_i) begin
                    ex_v = 0; ex_known = 0;
                end else begin
                    ex_v = id_v; ex_pc = id_pc; ex_hit = id_hit; ex_pred = id_pred; ex_known = id_known;
                    nxt = bp_hit_i ? bp_target_i : m_pc + 32'd4;
                    id_v = 1; id_pc = m_pc; id_hit = bp_hit_i; id_pred = nxt; id_known = 1;
                    m_pc = nxt;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
